// File: rtl/jk_drive_sequencer.sv
// Command sequencer for a downstream JK flip-flop: buffers {op,count} commands
// in a FIFO, replays each op on registered J/K and keeps a shadow Q model.
module jk_drive_sequencer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic                   clockPulse,
   input  logic                   reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [1:0]             cmd_op,
   input  logic [CNT_W-1:0]       cmd_count,
   output logic                   J,
   output logic                   K,
   output logic                   busy,
   output logic                   Q_model,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic {IDLE, APPLY} state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_mem  [DEPTH];
   logic [CNT_W-1:0] cnt_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             j_q, j_d, k_q, k_d;
   logic             busy_q, busy_d;
   logic             qm_q, qm_d;
   logic             push, pop, advance;
   logic [1:0]       head_op;
   logic [CNT_W-1:0] head_cnt;

   assign cmd_ready = !reset && (level_q < LVL_W'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign head_op   = op_mem[rd_ptr_q];
   assign head_cnt  = cnt_mem[rd_ptr_q];

   // Command storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clockPulse) begin
      if (push) begin
         op_mem[wr_ptr_q]  <= cmd_op;
         cnt_mem[wr_ptr_q] <= cmd_count;
      end
   end

   // Next-state: count down the active op, then pop the next or fall to idle.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      j_d     = j_q;
      k_d     = k_q;
      busy_d  = busy_q;
      pop     = 1'b0;
      advance = 1'b0;
      case (state_q)
         IDLE:  advance = 1'b1;
         APPLY: begin
            if (rem_q > CNT_W'(1)) rem_d = rem_q - CNT_W'(1);
            else                   advance = 1'b1;
         end
      endcase
      if (advance) begin
         if (level_q != '0) begin
            pop        = 1'b1;
            state_d    = APPLY;
            {j_d, k_d} = head_op;
            rem_d      = (head_cnt == '0) ? CNT_W'(1) : head_cnt;
            busy_d     = 1'b1;
         end else begin
            state_d = IDLE;
            j_d     = 1'b0;
            k_d     = 1'b0;
            rem_d   = '0;
            busy_d  = 1'b0;
         end
      end
   end

   // Shadow of the downstream flop, driven by the same registered J/K.
   always_comb begin
      qm_d = qm_q;
      case ({j_q, k_q})
         2'b01:   qm_d = 1'b0;
         2'b10:   qm_d = 1'b1;
         2'b11:   qm_d = ~qm_q;
         default: qm_d = qm_q;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
   end

   always_ff @(posedge clockPulse) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         rem_q    <= '0;
         j_q      <= 1'b0;
         k_q      <= 1'b0;
         busy_q   <= 1'b0;
         qm_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         rem_q    <= rem_d;
         j_q      <= j_d;
         k_q      <= k_d;
         busy_q   <= busy_d;
         qm_q     <= qm_d;
      end
   end

   assign J          = j_q;
   assign K          = k_q;
   assign busy       = busy_q;
   assign Q_model    = qm_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Bench for jk_drive_sequencer: fixed vector table, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_jk_drive_sequencer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

   logic             clockPulse = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_count;
   logic             J, K, busy, Q_model;
   logic [LVL_W-1:0] fifo_level;

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   jk_drive_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clockPulse (clockPulse),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_count  (cmd_count),
      .J          (J),
      .K          (K),
      .busy       (busy),
      .Q_model    (Q_model),
      .fifo_level (fifo_level)
   );

   always #5 clockPulse = ~clockPulse;

   typedef struct {
      bit       rst;
      bit       valid;
      bit [1:0] op;
      int       cnt;
      bit       ready;
      bit       j;
      bit       k;
      bit       bsy;
      bit       q;
      int       level;
   } vec_t;

   vec_t tbl[$];

   // Reference model: pending commands, plus the per-cycle J/K stream of the
   // command currently being applied (one entry per remaining cycle).
   bit [1:0] m_op[$];
   int       m_cnt[$];
   bit [1:0] m_stream[$];
   bit       m_q;
   bit       m_rst;

   function automatic vec_t mk(bit rst, bit valid, bit [1:0] op, int cnt,
                               bit ready, bit j, bit k, bit bsy, bit q, int level);
      vec_t v;
      v.rst = rst; v.valid = valid; v.op = op; v.cnt = cnt;
      v.ready = ready; v.j = j; v.k = k; v.bsy = bsy; v.q = q; v.level = level;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit v, input bit [1:0] o, input int c);
      bit [1:0] jk;
      int       pre;
      bit [1:0] pop_op;
      int       pop_cnt;
      if (r) begin
         m_op.delete(); m_cnt.delete(); m_stream.delete(); m_q = 1'b0;
         return;
      end
      jk  = (m_stream.size() != 0) ? m_stream[0] : 2'b00;
      pre = m_op.size();
      case (jk)
         2'b01:   m_q = 1'b0;
         2'b10:   m_q = 1'b1;
         2'b11:   m_q = ~m_q;
         default: ;
      endcase
      if (m_stream.size() > 1) begin
         void'(m_stream.pop_front());
      end else begin
         m_stream.delete();
         if (pre > 0) begin
            pop_op  = m_op.pop_front();
            pop_cnt = m_cnt.pop_front();
            for (int i = 0; i < ((pop_cnt == 0) ? 1 : pop_cnt); i++) m_stream.push_back(pop_op);
         end
      end
      if (v && pre < int'(DEPTH)) begin
         m_op.push_back(o);
         m_cnt.push_back(c);
      end
   endtask

   task automatic check_model();
      bit [1:0] jk;
      jk = (m_stream.size() != 0) ? m_stream[0] : 2'b00;
      check("model_ready", cmd_ready, 32'(!m_rst && m_op.size() < int'(DEPTH)));
      check("model_J",     J,         32'(jk[1]));
      check("model_K",     K,         32'(jk[0]));
      check("model_busy",  busy,      32'(m_stream.size() != 0));
      check("model_Q",     Q_model,   32'(m_q));
      check("model_level", fifo_level, 32'(m_op.size()));
   endtask

   // Drive one cycle of inputs (from a negedge), clock it, then compare.
   task automatic step(input bit v, input bit [1:0] o, input int c, input bit r);
      cmd_valid = v;
      cmd_op    = o;
      cmd_count = CNT_W'(c);
      reset     = r;
      m_rst     = r;
      @(posedge clockPulse);
      model_edge(r, v, o, c);
      cycle++;
      @(negedge clockPulse);
      check_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 0, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 2'b00, 0, 1'b1);
      step(1'b0, 2'b00, 0, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   initial begin
      int  tog, bcnt, hits;
      bit  prev_q, seen;

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_count = '0;
      m_rst     = 1'b1;
      @(negedge clockPulse);

      //                rst v  op  cnt  rdy J K bsy Q lvl
      tbl.push_back(mk(1, 1, 2'b11, 5,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b10, 3,  1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 1, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 1, 0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 0, 2'b00, 0,  0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 2'b11, 2,  1, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 1, 2'b01, 0,  1, 1, 1, 1, 0, 1));
      tbl.push_back(mk(0, 1, 2'b10, 1,  1, 1, 1, 1, 1, 2));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 0, 1, 1, 0, 1));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 1, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 2'b00, 0,  1, 0, 0, 0, 1, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].valid, tbl[i].op, tbl[i].cnt, tbl[i].rst);
         check($sformatf("vec%0d_ready", i), cmd_ready,  32'(tbl[i].ready));
         check($sformatf("vec%0d_J", i),     J,          32'(tbl[i].j));
         check($sformatf("vec%0d_K", i),     K,          32'(tbl[i].k));
         check($sformatf("vec%0d_busy", i),  busy,       32'(tbl[i].bsy));
         check($sformatf("vec%0d_Q", i),     Q_model,    32'(tbl[i].q));
         check($sformatf("vec%0d_level", i), fifo_level, 32'(tbl[i].level));
      end

      // Fill the FIFO behind a long command; a held 5th command must wait.
      do_reset();
      step(1'b1, 2'b11, 15, 1'b0);
      idle(1);
      step(1'b1, 2'b10, 3, 1'b0);
      step(1'b1, 2'b01, 3, 1'b0);
      step(1'b1, 2'b11, 3, 1'b0);
      step(1'b1, 2'b10, 3, 1'b0);
      check("fill_level_full", fifo_level, 32'd4);
      check("fill_ready_low",  cmd_ready,  32'd0);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         step(1'b1, 2'b01, 2, 1'b0);
         if (cmd_ready === 1'b1) seen = 1'b1;
      end
      check("fill_ready_returns", 32'(seen), 32'd1);
      check("fill_level_after_pop", fifo_level, 32'd3);
      step(1'b1, 2'b01, 2, 1'b0);
      check("fill_fifth_accepted", fifo_level, 32'd4);
      idle(40);

      // Maximum-count toggle: 15 toggles, no wrap of the remaining count.
      do_reset();
      step(1'b1, 2'b11, 15, 1'b0);
      prev_q = Q_model;
      tog    = 0;
      bcnt   = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         if (Q_model !== prev_q) tog++;
         prev_q = Q_model;
         if (busy === 1'b1) bcnt++;
      end
      check("toggle_count", 32'(tog),  32'd15);
      check("toggle_busy",  32'(bcnt), 32'd15);
      check("toggle_final_q", Q_model, 32'd1);

      // Reset during APPLY with three commands queued.
      do_reset();
      step(1'b1, 2'b10, 5, 1'b0);
      step(1'b1, 2'b11, 3, 1'b0);
      step(1'b1, 2'b01, 2, 1'b0);
      step(1'b1, 2'b11, 4, 1'b0);
      check("abort_pre_level", fifo_level, 32'd3);
      check("abort_pre_busy",  busy,       32'd1);
      step(1'b1, 2'b11, 7, 1'b1);
      check("abort_J",     J,          32'd0);
      check("abort_K",     K,          32'd0);
      check("abort_busy",  busy,       32'd0);
      check("abort_level", fifo_level, 32'd0);
      check("abort_Q",     Q_model,    32'd0);
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1);
         if (busy !== 1'b0 || J !== 1'b0 || K !== 1'b0) hits++;
      end
      check("abort_no_replay", 32'(hits), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         int c;
         c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
         step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), c,
              ($urandom_range(0, 63) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jk_drive_sequencer.md
Name: jk_drive_sequencer

Overview:
- Upstream stimulus stage for the JK flip-flop.
- Accepts queued J/K commands over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command onto registered J/K outputs for a programmable number of clock cycles.
- Keeps a shadow Q model that tracks the downstream flip-flop's Q cycle-for-cycle, so checkers need no probe into the flop.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, minimum 2
CNT_W, 4, width of the per-command repeat count

Ports:
clockPulse  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present on cmd_op/cmd_count
cmd_ready  output  1  FIFO can accept a command this cycle
cmd_op  input  2  {J,K}: 00 hold, 01 reset, 10 set, 11 toggle
cmd_count  input  CNT_W  cycles to apply the op; 0 is treated as 1
J  output  1  registered J drive to the downstream flip-flop
K  output  1  registered K drive to the downstream flip-flop
busy  output  1  high while in APPLY state
Q_model  output  1  shadow of the downstream Q
fifo_level  output  log2(DEPTH)+1  number of queued, not-yet-popped commands

Behaviour:
- Reset is synchronous and active-high; the clock is clockPulse. While reset is sampled high at an edge:
  - fifo_level=0; pointers cleared; state=IDLE
  - J=0, K=0, busy=0, Q_model=0
  - cmd_ready=0 while reset is high
- Reset mid-operation aborts the current command and discards all queued commands. No partial count is retained.
- Handshake:
  - cmd_ready = !reset && (fifo_level < DEPTH).
  - Push occurs at an edge where cmd_valid && cmd_ready.
  - cmd_op/cmd_count are sampled at that edge only.
  - cmd_valid while cmd_ready=0 is ignored, with no side effects.
- FIFO:
  - Circular buffer of DEPTH entries of {op, count}; pointers wrap modulo DEPTH.
  - A push and a pop at the same edge leave fifo_level unchanged.
  - A push at level DEPTH-1 with no pop makes the FIFO full, so cmd_ready drops the next cycle.
  - A push is never accepted at full, even if a pop happens at the same edge.
  - A pop at level 0 is never performed.
- FSM states: IDLE, APPLY.
  - IDLE, fifo_level>0:
    - pop head; J,K <= op
    - remaining <= (count==0 ? 1 : count)
    - busy <= 1; go to APPLY
  - IDLE, empty: J=K=0, busy=0, stay.
  - APPLY, remaining>1: remaining <= remaining-1; J,K held.
  - APPLY, remaining==1, FIFO non-empty: pop next command and load as from IDLE, back-to-back with no idle cycle.
  - APPLY, remaining==1, FIFO empty: J<=0, K<=0, busy<=0; go to IDLE.
- Latency:
  - A command pushed at edge N into an idle, empty FIFO drives J/K from edge N+1.
  - The FIFO is read the cycle after the write; no combinational bypass.
  - The op stays on J/K for exactly max(count,1) cycles.
- Q_model updates at each edge from the current registered J,K:
  - 00 hold
  - 01 -> 0
  - 10 -> 1
  - 11 -> ~Q_model
- Because Q_model uses the same edge and inputs as the downstream flop, it equals the flop's Q. Its first change from a command appears at edge N+2.
- Arithmetic:
  - remaining is CNT_W bits.
  - The maximum count, 2^CNT_W-1, applies the op for that many cycles; there is no wrap.
- Idle J=K=0 means "hold", so the downstream flop is never disturbed between commands.

Test Plan:
- Reset with cmd_valid=1 and op=11 driven -> cmd_ready=0, fifo_level=0, J=K=0, Q_model=0. First edge after reset release: cmd_ready=1.
- Push {10, count 3} at edge N into idle -> J=1,K=0 at edges N+1..N+3, busy=1 for those 3 cycles. Q_model=1 from N+2. J=K=0, busy=0 after N+4.
- Push {11,2}, {01,0}, {10,1} back-to-back -> J/K sequence 11,11,01,10 with no gaps. Q_model 0->1->0->0->1. busy falls after the 4th cycle.
- Fill FIFO with DEPTH=4 while one command is in APPLY with count 15 -> fifo_level=4, cmd_ready=0. A 5th cmd_valid is held and not accepted. At the first pop, cmd_ready=1 the next cycle and the 5th is accepted.
- Toggle {11, 15} from Q_model=0 -> Q_model alternates for 15 edges and ends at 1. remaining does not wrap.
- Assert reset during APPLY with 3 commands queued -> next edge: J=K=0, busy=0, fifo_level=0, Q_model=0. No queued command is executed afterward.
